pc_gen: RTL and testbench

- Parametrised next-generation program-counter unit for the fetch stage: PC register with reset vector, sequential increment, stall, and prioritised redirect sources (trap, branch/jump redirect, predicted call, predicted return).
- Contains a small circular return-address stack (RAS) so that fetch predicts function returns without waiting for execute.
- Sits between the fetch-side predecode and instruction memory; execute and CSR logic drive the redirect and trap inputs.

---
 rtl/pc_gen.sv | 90 +++++++++
 tb/tb_pc_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter: reset vector, sequential advance, stall, prioritised
// trap/redirect, and call/return prediction backed by a small circular return-address stack.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = 32'h80000000,
  parameter int                INST_BYTES = 4,
  parameter int                RAS_DEPTH  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         trap_valid_i,
  input  logic [ADDR_W-1:0]            trap_vec_i,
  input  logic                         redirect_valid_i,
  input  logic [ADDR_W-1:0]            redirect_pc_i,
  input  logic                         is_call_i,
  input  logic [ADDR_W-1:0]            call_target_i,
  input  logic                         is_ret_i,
  output logic [ADDR_W-1:0]            pc_o,
  output logic [ADDR_W-1:0]            pc_plus_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_empty_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(RAS_DEPTH);

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] pc_plus;
  logic [PTR_W-1:0]  top_inc;
  logic              push;

  assign pc_plus     = pc_q + ADDR_W'(INST_BYTES);
  assign top_inc     = top_q + PTR_W'(1);
  assign pc_o        = pc_q;
  assign pc_plus_o   = pc_plus;
  assign ras_count_o = cnt_q;
  assign ras_empty_o = (cnt_q == '0);

  // Next-PC selection; trap and redirect bypass the stall and leave the RAS untouched.
  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (trap_valid_i) begin
      pc_d = align(trap_vec_i);
    end else if (redirect_valid_i) begin
      pc_d = align(redirect_pc_i);
    end else if (en_i) begin
      if (is_call_i) begin
        pc_d  = align(call_target_i);
        push  = 1'b1;
        top_d = top_inc;
        cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
      end else if (is_ret_i && (cnt_q != '0)) begin
        pc_d  = align(ras_q[top_q]);
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      // A push into a full stack lands on the oldest slot, overwriting it.
      if (push) ras_q[top_inc] <= pc_plus;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequencing, stall, redirect/trap priority, RAS push/pop/overflow,
// address wrap and asynchronous reset.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        en, trap_valid, redirect_valid, is_call, is_ret;
  logic [31:0] trap_vec, redirect_pc, call_target;
  logic [31:0] pc, pc_plus;
  logic [2:0]  ras_count;
  logic        ras_empty;

  int nvec  = 0;
  int nfail = 0;

  pc_gen dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .en_i             (en),
    .trap_valid_i     (trap_valid),
    .trap_vec_i       (trap_vec),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .is_call_i        (is_call),
    .call_target_i    (call_target),
    .is_ret_i         (is_ret),
    .pc_o             (pc),
    .pc_plus_o        (pc_plus),
    .ras_count_o      (ras_count),
    .ras_empty_o      (ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_idle();
    en = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0; is_call = 1'b0; is_ret = 1'b0;
    trap_vec = '0; redirect_pc = '0; call_target = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl_idle();
    rst_n = 1'b0;
    #12;
    check("rst_pc", pc, 32'h80000000);
    check("rst_pc_plus", pc_plus, 32'h80000004);
    check("rst_count", {29'd0, ras_count}, 32'd0);
    check("rst_empty", {31'd0, ras_empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential advance
    en = 1'b1;
    step(); check("seq1", pc, 32'h80000004);
    step(); check("seq2", pc, 32'h80000008);
    step(); check("seq3", pc, 32'h8000000C);
    check("seq_empty", {31'd0, ras_empty}, 32'd1);
    step(); check("seq4", pc, 32'h80000010);

    // Stall with a call pending, then redirect while stalled
    en = 1'b0; is_call = 1'b1; call_target = 32'h80000400;
    step(); check("stall1_pc", pc, 32'h80000010);
    check("stall1_count", {29'd0, ras_count}, 32'd0);
    step(); check("stall2_pc", pc, 32'h80000010);
    is_call = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80000102;
    step(); check("redir_align", pc, 32'h80000100);
    redirect_pc = 32'h80000020;
    step(); check("redir_20", pc, 32'h80000020);

    // Call then return
    redirect_valid = 1'b0; en = 1'b1; is_call = 1'b1; call_target = 32'h80000400;
    step(); check("call_pc", pc, 32'h80000400);
    check("call_count", {29'd0, ras_count}, 32'd1);
    is_call = 1'b0;
    step(); step(); check("pre_ret_pc", pc, 32'h80000408);
    is_ret = 1'b1;
    step(); check("ret_pc", pc, 32'h80000024);
    check("ret_count", {29'd0, ras_count}, 32'd0);
    trap_valid = 1'b1; trap_vec = 32'h80001000;
    step(); check("trap_pc", pc, 32'h80001000);
    check("trap_count", {29'd0, ras_count}, 32'd0);

    // Trap and redirect must leave a non-empty RAS alone
    trap_valid = 1'b0; is_ret = 1'b0; is_call = 1'b1; call_target = 32'h80002000;
    step(); check("call2_count", {29'd0, ras_count}, 32'd1);
    is_call = 1'b0; trap_valid = 1'b1; trap_vec = 32'h80001003; is_ret = 1'b1;
    step(); check("trap_align", pc, 32'h80001000);
    check("trap_keep_count", {29'd0, ras_count}, 32'd1);
    trap_valid = 1'b0; is_ret = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h80000000; is_call = 1'b1; call_target = 32'h80000100;
    step(); check("redir_call_pc", pc, 32'h80000000);
    check("redir_call_count", {29'd0, ras_count}, 32'd1);
    redirect_valid = 1'b0;

    // Five calls overflow a 4-deep RAS
    for (int i = 0; i < 5; i++) begin
      call_target = 32'h80000000 + 32'h100 * (i + 1);
      step();
      check("chain_pc", pc, 32'h80000000 + 32'h100 * (i + 1));
    end
    check("full_count", {29'd0, ras_count}, 32'd4);
    is_call = 1'b0; is_ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("unwind_pc", pc, 32'h80000404 - 32'h100 * i);
    end
    check("unwind_count", {29'd0, ras_count}, 32'd0);
    check("unwind_empty", {31'd0, ras_empty}, 32'd1);
    step(); check("ret_empty_pc", pc, 32'h80000108);
    check("ret_empty_count", {29'd0, ras_count}, 32'd0);

    // Address wrap and simultaneous call/return
    is_ret = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    step(); check("wrap_pc", pc, 32'hFFFFFFFC);
    check("wrap_pc_plus", pc_plus, 32'h00000000);
    redirect_valid = 1'b0;
    step(); check("wrap_next", pc, 32'h00000000);
    is_call = 1'b1; is_ret = 1'b1; call_target = 32'h80000800;
    step(); check("callret_pc", pc, 32'h80000800);
    check("callret_count", {29'd0, ras_count}, 32'd1);
    is_ret = 1'b0; call_target = 32'h80000900;
    step(); check("call3_count", {29'd0, ras_count}, 32'd2);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 32'h80000000);
    check("arst_count", {29'd0, ras_count}, 32'd0);
    check("arst_empty", {31'd0, ras_empty}, 32'd1);
    @(negedge clk);
    ctl_idle();
    rst_n = 1'b1;
    en = 1'b1; is_ret = 1'b1;
    step(); check("post_rst_ret", pc, 32'h80000004);
    check("post_rst_count", {29'd0, ras_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
